tvg_gain_gen: RTL
=================

# tvg_gain_gen

Time-varying-gain (TVG) generator for the sonar receive chain. After each ping it produces the `amplify` operand consumed by the constant multiplier, so echo samples are scaled by a gain that grows with range. The sequence is: mute during transmit blanking, then a linear saturating ramp advanced per input sample, then hold. It sits directly upstream of the multiplier's `amplify` input and is clocked by the same sample-domain clock as the receive datapath.

## Interface
- `N`, 32, gain word width; matches the multiplier's `amplify` width.
- `CNT_W`, 16, width of the blanking and ramp sample counters.
- `STEP_W`, 16, width of the per-sample gain increment.

Ports:
- `clk_i`  in  1  system clock; single clock domain.
- `rst_ni`  in  1  synchronous, active-low reset.
- `start_i`  in  1  one-cycle ping-fired pulse; starts a sequence.
- `abort_i`  in  1  one-cycle pulse; terminates any sequence.
- `sample_valid_i`  in  1  one-cycle strobe per received ADC sample; advances counters and the ramp.
- `blank_len_i`  in  CNT_W  number of muted samples after the ping.
- `ramp_len_i`  in  CNT_W  number of ramp samples.
- `gain_init_i`  in  N  gain applied at ramp entry.
- `gain_step_i`  in  STEP_W  increment added per ramp sample, zero-extended to N bits.
- `gain_max_i`  in  N  saturation ceiling.
- `amplify_o`  out  N  gain word driving the multiplier; registered.
- `gain_valid_o`  out  1  high in RAMP and HOLD.
- `busy_o`  out  1  high in BLANK and RAMP.
- `done_o`  out  1  one-cycle pulse on entry to HOLD.

## Operation
- States: IDLE, BLANK, RAMP, HOLD. Reset gives IDLE, `amplify_o`=0, `gain_valid_o`=0, `busy_o`=0, `done_o`=0, counter=0.
- Config latch: all `*_len_i`, `gain_*_i` inputs are latched on accepted `start_i`. Input changes mid-sequence have no effect.
- IDLE or HOLD + `start_i`:
  - If `blank_len`≠0: go to BLANK, counter=`blank_len`, `amplify_o`=0.
  - Else: enter RAMP directly.
- `start_i` in BLANK or RAMP: ignored.
- BLANK:
  - `amplify_o`=0.
  - Each `sample_valid_i` decrements the counter.
  - On the strobe that makes the counter 0: enter RAMP.
- RAMP entry:
  - `amplify_o` = min(`gain_init`, `gain_max`).
  - counter=`ramp_len`.
  - If `ramp_len`=0: go straight to HOLD instead, with the same gain and a `done_o` pulse.
- RAMP, each `sample_valid_i`:
  - `amplify_o` = min(`amplify_o`+`gain_step`, `gain_max`). The sum is computed at N+1 bits, so carry-out also saturates to `gain_max`.
  - Counter decrements.
  - On reaching 0: enter HOLD and pulse `done_o`.
- HOLD: `amplify_o` frozen. Exit only via `start_i` (new ping) or `abort_i`.
- `abort_i` in any state: go to IDLE next cycle, `amplify_o`=0.
  - `abort_i` has priority over `start_i` and `sample_valid_i` in the same cycle.
- `sample_valid_i` in IDLE or HOLD: no effect.
- Reset mid-sequence: identical to the reset values above on the next edge; no residual state.

## Timing
- All outputs are registered. Each response appears on the clock edge after the input cycle that causes it.
- `start_i` at cycle t:
  - BLANK from t+1, `busy_o`=1 at t+1.
  - If `blank_len`=0: RAMP at t+1 with `amplify_o`=`gain_init`.
- Strobe-to-update latency: the `amplify_o` update for a RAMP strobe at cycle t is visible at t+1.
- Multiplier input: combinational from `amplify_o`, so the product sees the new gain from t+1.
- `sample_valid_i` may be asserted every cycle (full rate); no backpressure.
- `done_o`: exactly one cycle per sequence. Not asserted on abort.
- `gain_valid_o` rises with RAMP entry and falls one cycle after abort or reset.

## Structure
- Shared package `tvg_pkg`:
  - state encoding: 2-bit localparams `ST_IDLE`=0, `ST_BLANK`=1, `ST_RAMP`=2, `ST_HOLD`=3;
  - default widths `TVG_N`=32, `TVG_CNT_W`=16.
- One sub-module, `sat_add`: N-bit + zero-extended step, compared against a ceiling, returning min(sum, ceiling). It is combinational and reused by later AGC blocks.
- Top-level block content: FSM, counter, config registers, output register.

## Test plan
- **Basic ramp:** reset; `blank_len`=3, `ramp_len`=4, `gain_init`=10, `step`=5, `max`=100, `start_i`, then 8 consecutive strobes.
  - `amplify_o` must read 0,0,0,10,15,20,25,30.
  - `done_o` pulses once, with the update to 30.
  - The value then holds at 30.
- **Saturation:** `gain_init`=90, `step`=7, `max`=100, `ramp_len`=5, `blank_len`=0.
  - Sequence 90,97,100,100,100,100.
  - Separately, `gain_init`=0xFFFF_FFF0, `step`=0x20, `max`=0xFFFF_FFFF must give 0xFFFF_FFFF with no wrap.
- **Zero lengths:** `blank_len`=0, `ramp_len`=0, `gain_init`=42.
  - `amplify_o`=42 and `done_o`=1 on the cycle after `start_i`.
  - State is HOLD.
- **Abort priority:** `abort_i`, `start_i` and `sample_valid_i` all asserted together mid-RAMP.
  - Next cycle: IDLE, `amplify_o`=0, `busy_o`=0, no `done_o`.
- **Restart and ignored start:**
  - `start_i` during BLANK: ignored, and the counter keeps counting down.
  - `start_i` in HOLD: re-latches config and returns `amplify_o` to 0 (new `blank_len`=2).
- **Reset mid-ramp:** `rst_ni`=0 for one cycle at `amplify_o`=25.
  - Next cycle all outputs are 0 and the state is IDLE.

Source files
------------

// File: rtl/tvg_pkg.sv
// Shared definitions for the time-varying-gain generator and related AGC blocks.
package tvg_pkg;

  localparam int TVG_N     = 32;
  localparam int TVG_CNT_W = 16;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_RAMP  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    BLANK = ST_BLANK,
    RAMP  = ST_RAMP,
    HOLD  = ST_HOLD
  } tvg_state_e;

endpackage

// File: rtl/tvg_gain_gen_if.sv
// Control, configuration and gain-output bundle of the TVG generator.
interface tvg_gain_gen_if import tvg_pkg::*; #(
  parameter int N      = TVG_N,
  parameter int CNT_W  = TVG_CNT_W,
  parameter int STEP_W = 16
) ();

  logic              start_i;
  logic              abort_i;
  logic              sample_valid_i;
  logic [CNT_W-1:0]  blank_len_i;
  logic [CNT_W-1:0]  ramp_len_i;
  logic [N-1:0]      gain_init_i;
  logic [STEP_W-1:0] gain_step_i;
  logic [N-1:0]      gain_max_i;
  logic [N-1:0]      amplify_o;
  logic              gain_valid_o;
  logic              busy_o;
  logic              done_o;

  modport master (
    output start_i, abort_i, sample_valid_i,
    output blank_len_i, ramp_len_i, gain_init_i, gain_step_i, gain_max_i,
    input  amplify_o, gain_valid_o, busy_o, done_o
  );

  modport slave (
    input  start_i, abort_i, sample_valid_i,
    input  blank_len_i, ramp_len_i, gain_init_i, gain_step_i, gain_max_i,
    output amplify_o, gain_valid_o, busy_o, done_o
  );

endinterface

// File: rtl/tvg_gain_gen_sat_add.sv
// Saturating add: min(a + zero-extended step, ceiling), evaluated at N+1 bits so
// a carry-out clips to the ceiling instead of wrapping.
module sat_add #(
  parameter int N      = 32,
  parameter int STEP_W = 16
) (
  input  logic [N-1:0]      a,
  input  logic [STEP_W-1:0] step,
  input  logic [N-1:0]      ceil,
  output logic [N-1:0]      y
);

  logic [N:0] sum;

  function automatic logic [N-1:0] clip(input logic [N:0] s, input logic [N-1:0] c);
    return (s > {1'b0, c}) ? c : s[N-1:0];
  endfunction

  assign sum = {1'b0, a} + {{(N + 1 - STEP_W){1'b0}}, step};
  assign y   = clip(sum, ceil);

endmodule

// File: rtl/tvg_gain_gen.sv
// TVG generator: mute for blank_len samples after a ping, ramp the gain linearly
// with saturation for ramp_len samples, then hold until the next ping or abort.
module tvg_gain_gen import tvg_pkg::*; #(
  parameter int N      = TVG_N,
  parameter int CNT_W  = TVG_CNT_W,
  parameter int STEP_W = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  tvg_gain_gen_if.slave  bus
);

  tvg_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N-1:0]      amp_q, amp_d;
  logic              done_q, done_d;
  logic              cfg_ld;
  logic              enter_ramp;

  logic [CNT_W-1:0]  ramp_len_q;
  logic [N-1:0]      init_q;
  logic [N-1:0]      max_q;
  logic [STEP_W-1:0] step_q;

  logic              from_cfg;
  logic [N-1:0]      entry_init, entry_max, entry_gain, ramp_gain;
  logic [CNT_W-1:0]  entry_len;

  // A ramp entered straight from a ping uses the live inputs (they are being
  // latched this very cycle); one entered after blanking uses the latched copy.
  assign from_cfg   = (state_q == BLANK);
  assign entry_init = from_cfg ? init_q     : bus.gain_init_i;
  assign entry_max  = from_cfg ? max_q      : bus.gain_max_i;
  assign entry_len  = from_cfg ? ramp_len_q : bus.ramp_len_i;

  sat_add #(.N(N), .STEP_W(STEP_W)) u_entry (
    .a(entry_init), .step({STEP_W{1'b0}}), .ceil(entry_max), .y(entry_gain)
  );

  sat_add #(.N(N), .STEP_W(STEP_W)) u_ramp (
    .a(amp_q), .step(step_q), .ceil(max_q), .y(ramp_gain)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    amp_d      = amp_q;
    done_d     = 1'b0;
    cfg_ld     = 1'b0;
    enter_ramp = 1'b0;
    if (bus.abort_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      amp_d   = '0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (bus.start_i) begin
            cfg_ld = 1'b1;
            if (bus.blank_len_i != '0) begin
              state_d = BLANK;
              cnt_d   = bus.blank_len_i;
              amp_d   = '0;
            end else begin
              enter_ramp = 1'b1;
            end
          end
        end
        BLANK: begin
          if (bus.sample_valid_i) begin
            if (cnt_q == CNT_W'(1)) enter_ramp = 1'b1;
            else                    cnt_d = cnt_q - 1'b1;
          end
        end
        RAMP: begin
          if (bus.sample_valid_i) begin
            amp_d = ramp_gain;
            if (cnt_q == CNT_W'(1)) begin
              state_d = HOLD;
              cnt_d   = '0;
              done_d  = 1'b1;
            end else begin
              cnt_d = cnt_q - 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
      if (enter_ramp) begin
        amp_d = entry_gain;
        if (entry_len == '0) begin
          state_d = HOLD;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          state_d = RAMP;
          cnt_d   = entry_len;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      amp_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      amp_q   <= amp_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ramp_len_q <= '0;
      init_q     <= '0;
      max_q      <= '0;
      step_q     <= '0;
    end else if (cfg_ld) begin
      ramp_len_q <= bus.ramp_len_i;
      init_q     <= bus.gain_init_i;
      max_q      <= bus.gain_max_i;
      step_q     <= bus.gain_step_i;
    end
  end

  assign bus.amplify_o    = amp_q;
  assign bus.done_o       = done_q;
  assign bus.gain_valid_o = (state_q == RAMP) || (state_q == HOLD);
  assign bus.busy_o       = (state_q == BLANK) || (state_q == RAMP);

endmodule
